// File: rtl/multdiv_seq.sv
// Purpose : iterative signed 32-bit multiply / divide sequencer driving an external thermometer step register.
// Latency : 34 cycles from the ctrl edge to the data_resultRDY pulse (1 cycle for zero operands with MULTDIV_EARLY_ZERO_EN).
// Backpressure: none; ctrl pulses outside IDLE are dropped, the result is a one-cycle pulse and is not queued.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-high reset
//   ctrl_MULT, ctrl_DIV           start pulses (both high -> multiply)
//   data_operandA/B               signed multiplicand/dividend, multiplier/divisor
//   step_therm                    thermometer count from the step register (MSB set = all steps done)
//   ctr_clr, ctr_run              clear / shift requests to the step register
//   data_result, data_exception   product low word or quotient, overflow / divide-by-zero flag
//   data_resultRDY                one-cycle result-valid pulse
// Optional build macro: MULTDIV_EARLY_ZERO_EN (zero operand finishes one cycle after the ctrl edge).
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] step_therm,
    output logic             ctr_clr,
    output logic             ctr_run,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, ZERO, DONE} state_t;

    state_t state, state_nxt;

    logic                 start, start_div, early_zero, steps_done;
    logic [WIDTH:0]       mag_a, mag_b;
    logic                 op_div, neg, b_zero;
    logic [WIDTH:0]       mcand;       // multiplicand (MULT) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0]   acc;         // {partial product hi, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]       addend, mul_sum, rem_sh;
    logic [WIDTH+1:0]     diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_s;
    logic [WIDTH:0]       quo_s;
    logic [WIDTH-1:0]     fin_result;
    logic                 fin_exc;
    logic                 unused_bits;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign steps_done = step_therm[WIDTH-1];

`ifdef MULTDIV_EARLY_ZERO_EN
    assign early_zero = (data_operandA == '0) || (data_operandB == '0);
`else
    assign early_zero = 1'b0;
`endif

    // Magnitudes are formed one bit wider so that |0x80000000| does not wrap.
    assign mag_a = data_operandA[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, data_operandA})
                                          : {1'b0, data_operandA};
    assign mag_b = data_operandB[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, data_operandB})
                                          : {1'b0, data_operandB};

    // Shift-add step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    assign addend   = acc[0] ? mcand : '0;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = {1'b0, rem_sh} - {1'b0, mcand};
    assign div_next = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

    // Sign is applied once, after all iterations.
    assign prod_s = neg ? ({(2*WIDTH){1'b0}} - acc) : acc;
    assign quo_s  = neg ? ({(WIDTH+1){1'b0}} - {1'b0, acc[WIDTH-1:0]}) : {1'b0, acc[WIDTH-1:0]};

    always_comb begin
        fin_result = '0;
        fin_exc    = 1'b0;
        if (op_div) begin
            if (b_zero) begin
                fin_result = '0;
                fin_exc    = 1'b1;
            end else begin
                fin_result = quo_s[WIDTH-1:0];
                fin_exc    = quo_s[WIDTH] ^ quo_s[WIDTH-1];   // only +2^31 (MIN / -1) lands here
            end
        end else begin
            fin_result = prod_s[WIDTH-1:0];
            fin_exc    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        end
    end

    assign unused_bits = ^{diff[WIDTH], step_therm[WIDTH-2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ctr_clr        = 1'b0;
        ctr_run        = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = early_zero ? ZERO : CLEAR;
            CLEAR: begin
                ctr_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (steps_done) state_nxt = DONE;
                else            ctr_run   = 1'b1;
            end
            ZERO:  state_nxt = DONE;
            DONE: begin
                data_resultRDY = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_div         <= 1'b0;
            neg            <= 1'b0;
            b_zero         <= 1'b0;
            mcand          <= '0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_div <= start_div;
                neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                b_zero <= (data_operandB == '0);
                mcand  <= start_div ? mag_b : mag_a;
                acc    <= {{WIDTH{1'b0}}, (start_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0])};
            end
            if (state == RUN) begin
                if (steps_done) begin
                    data_result    <= fin_result;
                    data_exception <= fin_exc;
                end else begin
                    acc <= op_div ? div_next : mul_next;
                end
            end
            if (state == ZERO) begin
                data_result    <= '0;
                data_exception <= op_div & b_zero;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] step_therm;
    logic        ctr_clr, ctr_run;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    multdiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .step_therm(step_therm),
        .ctr_clr(ctr_clr), .ctr_run(ctr_run), .data_result(data_result),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY)
    );

    always #5 clk = ~clk;

    // Behavioural shift-left step register sitting upstream of the sequencer.
    always @(posedge clk or posedge reset) begin
        if (reset)        step_therm <= '0;
        else if (ctr_clr) step_therm <= '0;
        else if (ctr_run) step_therm <= {step_therm[30:0], 1'b1};
    end

    int errors = 0;
    int checks = 0;

    // Observations of the last operation.
    int          r_lat, r_clr, r_run, r_rdy, r_both;
    logic [31:0] r_res;
    logic        r_exc;

    typedef struct {
        int          op;    // 0 = MULT, 1 = DIV, 2 = both ctrl lines
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_ZERO_EN
        if (a == 0 || b == 0) return 1;
`endif
        return 34;
    endfunction

    // Reference: plain 64-bit signed arithmetic.
    task automatic ref_model(input int op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic exc);
        longint p, q;
        if (op != 1) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end else if (b == 0) begin
            res = '0;
            exc = 1'b1;
        end else begin
            q   = longint'($signed(a)) / longint'($signed(b));
            res = q[31:0];
            exc = (q > 64'sd2147483647) || (q < -64'sd2147483648);
        end
    endtask

    // Issues one operation; inject_k > 0 pulses ctrl_DIV so that it is sampled at edge E<inject_k>.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int inject_k);
        @(negedge clk);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = (op != 1);
        ctrl_DIV      = (op != 0);
        r_lat = -1; r_clr = 0; r_run = 0; r_rdy = 0; r_both = 0;
        r_res = 'x; r_exc = 1'bx;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);   // observes the interval after edge E<k>
            if (ctr_clr) r_clr++;
            if (ctr_run) r_run++;
            if (ctr_clr && ctr_run) r_both++;
            if (data_resultRDY) begin
                r_rdy++;
                if (r_lat < 0) begin
                    r_lat = k;
                    r_res = data_result;
                    r_exc = data_exception;
                end
            end
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = (k == inject_k - 1);
            data_operandA = $urandom;
            data_operandB = $urandom;
            if (r_lat >= 0 && k >= r_lat + 2) break;
        end
        ctrl_DIV = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [31:0] eres, input logic eexc, input int elat);
        chk({tag, ".result"}, {32'd0, r_res}, {32'd0, eres});
        chk({tag, ".exc"}, {63'd0, r_exc}, {63'd0, eexc});
        chk({tag, ".rdy_latency"}, 64'(r_lat), 64'(elat));
        chk({tag, ".rdy_pulses"}, 64'(r_rdy), 64'd1);
        chk({tag, ".clr_cycles"}, 64'(r_clr), (elat == 1) ? 64'd0 : 64'd1);
        chk({tag, ".run_cycles"}, 64'(r_run), (elat == 1) ? 64'd0 : 64'd32);
        chk({tag, ".clr_run_overlap"}, 64'(r_both), 64'd0);
        chk({tag, ".result_held"}, {32'd0, data_result}, {32'd0, eres});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] t;
        case ($urandom_range(0, 7))
            0: t = 32'h0;
            1: t = 32'h8000_0000;
            2: t = 32'hFFFF_FFFF;
            3: t = 32'h7FFF_FFFF;
            4: t = $urandom_range(0, 1000);
            5: begin t = $urandom_range(1, 1000); t = -t; end
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        logic [31:0] eres;
        logic        eexc;
        int          op;
        logic [31:0] a, b;

        tbl[0]  = '{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0};
        tbl[2]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        tbl[3]  = '{1, 32'd5,          32'd0,         32'h0,         1'b1};
        tbl[4]  = '{0, 32'h0001_0000,  32'h0001_0000, 32'h0,         1'b1};
        tbl[5]  = '{0, 32'h0000_8000,  32'h0000_8000, 32'h4000_0000, 1'b0};
        tbl[6]  = '{2, 32'd6,          32'd7,         32'd42,        1'b0};
        tbl[7]  = '{1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        tbl[8]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        tbl[9]  = '{0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        tbl[10] = '{1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        tbl[11] = '{0, 32'd0,          32'hFFFF_FFFB, 32'h0,         1'b0};

        // Reset state.
        #1 reset = 1'b1;
        #1;
        chk("reset.result", {32'd0, data_result}, 64'd0);
        chk("reset.exc", {63'd0, data_exception}, 64'd0);
        chk("reset.rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("reset.clr", {63'd0, ctr_clr}, 64'd0);
        chk("reset.run", {63'd0, ctr_run}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0);
            check_op($sformatf("vec%0d", i), tbl[i].res, tbl[i].exc, exp_lat(tbl[i].a, tbl[i].b));
        end

        // A DIV pulse mid-MULT must be ignored.
        run_op(0, 32'd3, 32'd5, 10);
        check_op("ignore_div_midrun", 32'd15, 1'b0, 34);

        // Asynchronous reset in the middle of an iteration run.
        @(negedge clk);
        data_operandA = 32'd1234;
        data_operandB = 32'd5678;
        ctrl_MULT     = 1'b1;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrun.run_active", {63'd0, ctr_run}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrun_reset.result", {32'd0, data_result}, 64'd0);
        chk("midrun_reset.exc", {63'd0, data_exception}, 64'd0);
        chk("midrun_reset.rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("midrun_reset.clr", {63'd0, ctr_clr}, 64'd0);
        chk("midrun_reset.run", {63'd0, ctr_run}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 32'd2, 32'd3, 0);
        check_op("post_reset", 32'd6, 1'b0, 34);

        // Randomised operations against the arithmetic reference.
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 2);
            a  = pick();
            b  = pick();
            ref_model(op, a, b, eres, eexc);
            run_op(op, a, b, 0);
            check_op($sformatf("rnd%0d_op%0d_%0h_%0h", n, op, a, b), eres, eexc, exp_lat(a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide sequencer for the ALU multdiv path.
- Consumes the thermometer step count produced by the shift-left step register, which sits directly upstream.
- Drives that register's clear/run controls and runs one shift-add (MULT) or restoring-subtract (DIV) iteration per clock.
- Presents the result with a one-cycle ready pulse to the writeback stage.

Parameters:
- WIDTH, 32, operand/result width and iteration count. step_therm is WIDTH bits. Only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ctrl_MULT  input  1  start-multiply pulse, sampled on clk edge
- ctrl_DIV  input  1  start-divide pulse, sampled on clk edge
- data_operandA  input  32  multiplicand / dividend, signed
- data_operandB  input  32  multiplier / divisor, signed
- step_therm  input  32  thermometer count from step register; bit 31 set = all steps done
- ctr_clr  output  1  step-register clear request; register reads 0 after the edge
- ctr_run  output  1  step-register shift request; shifts in a 1 per edge
- data_result  output  32  product low word or quotient, signed
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle result-valid pulse

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal accumulators 0.
- Step-register contract:
  - ctr_clr at an edge -> step_therm=0 after that edge.
  - ctr_run at an edge -> step_therm={step_therm[30:0],1}.
  - Neither asserted -> step_therm holds.
  - ctr_clr and ctr_run are never both 1.
- States:
  - IDLE -> CLEAR on an edge with ctrl_MULT|ctrl_DIV. Latch operands and op at that edge. Both ctrl high -> MULT; DIV is dropped.
  - CLEAR (ctr_clr=1, 1 cycle) -> RUN.
  - RUN (ctr_run=1 while step_therm[31]==0): one iteration per edge. When step_therm[31]==1, the edge stores the final result and goes to DONE; ctr_run=0 in that cycle.
  - DONE (data_resultRDY=1, 1 cycle) -> IDLE.
- Latency: ctrl sampled at edge E0. CLEAR at E1. Iterations at E2..E33. DONE entered at E34. data_resultRDY high between E34 and E35.
- data_result and data_exception hold their value until the next DONE or reset.
- ctrl_MULT/ctrl_DIV while not in IDLE: ignored. No queueing. Operand changes after E0 have no effect.
- MULT:
  - Radix-2 shift-add on operand magnitudes into a 64-bit product; sign applied in the final step.
  - data_result = product[31:0].
  - data_exception=1 iff the 64-bit signed product is not the sign-extension of product[31:0].
- DIV:
  - Restoring division on magnitudes; quotient truncates toward zero; negated if operand signs differ. Remainder discarded.
  - B==0 -> data_result=0, data_exception=1, full latency.
  - A=0x80000000 with B=-1 -> data_result=0x80000000, data_exception=1.
- Magnitude of 0x80000000 is handled in 33-bit internal width; no wrap.

Optional Feature:
- Macro: MULTDIV_EARLY_ZERO_EN
- Defined: if operandB==0 (MULT or DIV) or operandA==0 (MULT or DIV), go IDLE -> DONE directly at E1. data_resultRDY is high between E1 and E2. Result and exception values are as specified for the full path. No ctr_clr or ctr_run is issued.
- Undefined: all operations take the full 34-cycle path.

Test Plan:
- MULT A=7, B=-3 at E0 -> ctr_clr high for E0–E1 only; ctr_run high 32 cycles; rdy pulse E34–E35; result 0xFFFFFFEB, exc 0.
- DIV A=-100, B=7 -> result 0xFFFFFFF2 (-14), exc 0, rdy at E34. DIV 0x80000000 / -1 -> result 0x80000000, exc 1.
- DIV A=5, B=0 -> result 0, exc 1. Without macro rdy at E34; with MULTDIV_EARLY_ZERO_EN rdy at E1 and no ctr_clr/ctr_run.
- MULT 0x00010000 * 0x00010000 -> result 0x00000000, exc 1. MULT 0x00008000 * 0x00008000 -> 0x40000000, exc 0.
- ctrl_DIV pulse at E10 during a MULT, and ctrl_MULT+ctrl_DIV together at idle -> first ignored (single rdy, MULT result); second runs MULT.
- reset asserted mid-RUN (E15) -> outputs 0 immediately, state IDLE. A new MULT 2*3 afterwards -> 6, rdy 34 cycles after its ctrl edge.
